regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Single-write-port sequencer for the 32x32 register file. Two writeback sources share the one port:
//   - A: in-order pipeline writeback (highest priority, never stalled).
//   - B: long-latency unit (mult/div/load), buffered in a small FIFO.
//  Also keeps a busy scoreboard so decode can stall on registers with an outstanding B write.
//  Sits between the writeback stage and the register file write port (write enable, write address, write data).
// PARAMETERS
//  FIFO_DEPTH  2   number of buffered B writes (power of 2, >=2)
//  NUM_REGS    32  register count; index width = $clog2(NUM_REGS) = 5
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   asynchronous, active-high reset
//  a_valid     in   1   pipeline writeback request, always accepted
//  a_reg       in   5   destination register for A
//  a_data      in   32  write data for A
//  b_valid     in   1   long-latency writeback request
//  b_ready     out  1   B request accepted this cycle when b_valid & b_ready
//  b_reg       in   5   destination register for B
//  b_data      in   32  write data for B
//  issue_valid in   1   long-latency op issued; marks issue_reg busy
//  issue_reg   in   5   destination register of the issued op
//  query_reg1  in   5   decode source/destination lookup port 1
//  query_reg2  in   5   decode source/destination lookup port 2
//  busy1       out  1   busy[query_reg1], combinational
//  busy2       out  1   busy[query_reg2], combinational
//  wr_en       out  1   register file write enable
//  wr_reg      out  5   register file write address
//  wr_data     out  32  register file write data
//  pending     out  2   FIFO occupancy (width $clog2(FIFO_DEPTH)+1)
// BEHAVIOUR
//  Reset (async, while reset=1):
//   - FIFO empty; busy[] all 0; pending=0.
//   - b_ready=0 and wr_en=0 while reset is asserted.
//   - A reset asserted mid-operation discards all buffered B writes.
//  Register 0:
//   - Any A write, B write or issue targeting reg 0 is dropped and never drives wr_en.
//   - busy for reg 0 is always 0.
//   - A B request to reg 0 is still handshaken (b_ready as normal) but is not enqueued.
//  Port select (combinational, each cycle):
//   - A live (a_valid & a_reg!=0): wr_en=1, wr_reg=a_reg, wr_data=a_data. FIFO head holds.
//   - Otherwise, FIFO non-empty: drive the head entry and pop it at the clk edge.
//   - Otherwise: wr_en=0; wr_reg and wr_data are don't-care and are driven 0.
//  B path:
//   - b_ready = ~full.
//   - An accepted request is enqueued at the edge; earliest write is the next cycle (min latency 1).
//   - Push and pop in the same cycle while full is not allowed, because b_ready=0 when full.
//   - Push and pop in the same cycle while not full: occupancy is unchanged.
//   - FIFO order is preserved. Starvation of B is bounded only by A idle cycles (decided).
//  Scoreboard:
//   - busy[r] is set at the edge after issue_valid with issue_reg=r.
//   - busy[r] is cleared at the edge where a B entry for r is written to the port.
//   - Set and clear of the same r in one cycle: set wins.
//  Protocol rules (bench asserts; RTL behaviour still defined):
//   - Decode must not issue to a busy register. If it does, busy stays set and both writes occur in arrival order.
//   - An A write to a busy register writes immediately; the later B write still overwrites it.
// STRUCTURE
//  - Shared package mips_pkg: REG_ADDR_W=5, DATA_W=32, REG_ZERO=5'd0,
//    typedef struct packed {logic [4:0] rd; logic [31:0] data;} wb_req_t.
//  - Sub-module wb_fifo: parameterised sync FIFO of wb_req_t with async reset, full/empty/count.
//  - Top level holds the port mux and the busy[NUM_REGS-1:0] flop vector.
// TESTING
//  1. A only: a_valid=1, a_reg=5, a_data=32'hDEAD_BEEF -> same cycle wr_en=1, wr_reg=5, wr_data=DEADBEEF; pending stays 0.
//  2. Issue then B: issue reg 8, then B write to reg 8 with 32'h1234 and A idle
//     -> busy1(q=8)=1 from the next cycle; write to reg 8 one cycle after acceptance; busy clears after that edge.
//  3. Contention: A valid for 4 cycles (regs 1-4) while B pushes regs 9,10,11
//     -> b_ready drops after 2 pushes; A writes 1-4 in order, then 9,10,11 in order; pending 2->0.
//  4. Reg 0: a_reg=0 with B head=reg 7 -> port goes to B (wr_reg=7); a B push to reg 0 is accepted, never written, pending unchanged.
//  5. Simultaneous events: issue reg 7 in the same cycle that B for reg 7 drains -> busy[7] remains 1.
//  6. Reset mid-operation: FIFO holding 2 entries, busy[3]=1; assert reset between edges
//     -> immediately wr_en=0, b_ready=0, pending=0, busy all 0; no write after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared writeback types and register-file geometry.
package mips_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests with asynchronous reset and occupancy count.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  wb_req_t                   din,
  input  logic                      pop,
  output wb_req_t                   dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  wb_req_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback (A, priority) and a
// buffered long-latency source (B); tracks registers with an outstanding B write.
module regfile_wb_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          a_valid,
  input  logic [REG_ADDR_W-1:0]         a_reg,
  input  logic [DATA_W-1:0]             a_data,
  input  logic                          b_valid,
  output logic                          b_ready,
  input  logic [REG_ADDR_W-1:0]         b_reg,
  input  logic [DATA_W-1:0]             b_data,
  input  logic                          issue_valid,
  input  logic [REG_ADDR_W-1:0]         issue_reg,
  input  logic [REG_ADDR_W-1:0]         query_reg1,
  input  logic [REG_ADDR_W-1:0]         query_reg2,
  output logic                          busy1,
  output logic                          busy2,
  output logic                          wr_en,
  output logic [REG_ADDR_W-1:0]         wr_reg,
  output logic [DATA_W-1:0]             wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   pending
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                a_live;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  wb_req_t             fifo_din, fifo_head;

  assign a_live    = a_valid & (a_reg != REG_ZERO);
  assign b_ready   = ~fifo_full & ~reset;
  // Reg-0 requests complete the handshake but are never buffered.
  assign fifo_push = b_valid & b_ready & (b_reg != REG_ZERO);
  assign fifo_pop  = ~a_live & ~fifo_empty & ~reset;
  assign fifo_din  = '{rd: b_reg, data: b_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending)
  );

  always_comb begin
    wr_en   = 1'b0;
    wr_reg  = '0;
    wr_data = '0;
    if (!reset) begin
      if (a_live) begin
        wr_en   = 1'b1;
        wr_reg  = a_reg;
        wr_data = a_data;
      end else if (!fifo_empty) begin
        wr_en   = 1'b1;
        wr_reg  = fifo_head.rd;
        wr_data = fifo_head.data;
      end
    end
  end

  // Clear on drain first so a same-cycle issue to the same register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (fifo_pop) busy_d[fifo_head.rd] = 1'b0;
    if (issue_valid && (issue_reg != REG_ZERO)) busy_d[issue_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy1 = busy_q[query_reg1];
  assign busy2 = busy_q[query_reg2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scoreboard bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, b_ready, issue_valid;
  logic [4:0]  a_reg, b_reg, issue_reg, query_reg1, query_reg2, wr_reg;
  logic [31:0] a_data, b_data, wr_data;
  logic        busy1, busy2, wr_en;
  logic [1:0]  pending;

  int checks = 0;
  int errors = 0;

  wr_t         qa[$];
  wr_t         qb[$];
  logic [31:0] busy_m;
  logic        b_acc, pop_b;
  int          bidx, n;
  logic [4:0]  bregs [3];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .FIFO_DEPTH (2),
    .NUM_REGS   (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .a_valid     (a_valid),
    .a_reg       (a_reg),
    .a_data      (a_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_reg       (b_reg),
    .b_data      (b_data),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .query_reg1  (query_reg1),
    .query_reg2  (query_reg2),
    .busy1       (busy1),
    .busy2       (busy2),
    .wr_en       (wr_en),
    .wr_reg      (wr_reg),
    .wr_data     (wr_data),
    .pending     (pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    a_valid     = 1'b0;
    a_reg       = '0;
    a_data      = '0;
    b_valid     = 1'b0;
    b_reg       = '0;
    b_data      = '0;
    issue_valid = 1'b0;
    issue_reg   = '0;
  endtask

  task automatic drive_a(input logic [4:0] r, input logic [31:0] d);
    a_valid = 1'b1;
    a_reg   = r;
    a_data  = d;
    if (r != 5'd0) qa.push_back('{rd: r, d: d});
  endtask

  task automatic drive_b(input logic [4:0] r, input logic [31:0] d);
    b_valid = 1'b1;
    b_reg   = r;
    b_data  = d;
  endtask

  // Check the port against the scoreboard at negedge, then advance the model at posedge.
  task automatic cycle(input string tag);
    wr_t  e;
    logic exp_en, exp_rdy;
    @(negedge clk);
    pop_b   = 1'b0;
    exp_en  = (qa.size() > 0) || (qb.size() > 0);
    exp_rdy = (qb.size() < 2);
    chk({tag, ".wr_en"}, wr_en, exp_en);
    if (exp_en) begin
      if (qa.size() > 0) begin
        e = qa.pop_front();
      end else begin
        e     = qb[0];
        pop_b = 1'b1;
      end
      chk({tag, ".wr_reg"}, wr_reg, e.rd);
      chk({tag, ".wr_data"}, wr_data, e.d);
    end
    chk({tag, ".b_ready"}, b_ready, exp_rdy);
    chk({tag, ".pending"}, pending, qb.size());
    chk({tag, ".busy1"}, busy1, busy_m[query_reg1]);
    chk({tag, ".busy2"}, busy2, busy_m[query_reg2]);
    b_acc = b_valid && exp_rdy;
    @(posedge clk);
    if (pop_b) begin
      busy_m[qb[0].rd] = 1'b0;
      void'(qb.pop_front());
    end
    if (b_acc && (b_reg != 5'd0)) qb.push_back('{rd: b_reg, d: b_data});
    if (issue_valid && (issue_reg != 5'd0)) busy_m[issue_reg] = 1'b1;
    #1;
  endtask

  initial begin
    busy_m     = '0;
    query_reg1 = '0;
    query_reg2 = '0;
    clr();
    reset = 1'b1;
    bregs[0] = 5'd9;
    bregs[1] = 5'd10;
    bregs[2] = 5'd11;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.wr_en", wr_en, 1'b0);
    chk("rst.b_ready", b_ready, 1'b0);
    chk("rst.pending", pending, 2'd0);
    reset = 1'b0;
    #1;

    // 1: A only
    clr(); drive_a(5'd5, 32'hDEAD_BEEF); cycle("t1");

    // 2: issue then B
    query_reg1 = 5'd8;
    clr(); issue_valid = 1'b1; issue_reg = 5'd8; cycle("t2.issue");
    clr(); drive_b(5'd8, 32'h1234); cycle("t2.push");
    chk("t2.busy_set", busy1, 1'b1);
    clr(); cycle("t2.write");
    clr(); cycle("t2.after");
    chk("t2.busy_clr", busy1, 1'b0);

    // 3: contention, A regs 1-4 while B pushes 9,10,11
    bidx = 0;
    for (int i = 1; i <= 4; i++) begin
      clr(); drive_a(5'(i), 32'h111 * i);
      if (bidx < 3) drive_b(bregs[bidx], 32'hB00 + 32'(bregs[bidx]));
      cycle("t3.a");
      if (b_acc && bidx < 3) bidx++;
    end
    chk("t3.two_pushed", bidx, 2);
    n = 0;
    while ((bidx < 3 || qb.size() > 0) && n < 20) begin
      clr();
      if (bidx < 3) drive_b(bregs[bidx], 32'hB00 + 32'(bregs[bidx]));
      cycle("t3.drain");
      if (b_acc && bidx < 3) bidx++;
      n++;
    end
    chk("t3.drained", qb.size(), 0);

    // 4: reg 0 from A falls through to B; B push to reg 0 is dropped
    clr(); drive_a(5'd3, 32'h33); drive_b(5'd7, 32'h77); cycle("t4.fill");
    clr(); drive_a(5'd0, 32'hFFFF); drive_b(5'd0, 32'hAAAA); cycle("t4.zero");
    chk("t4.b0_acc", b_acc, 1'b1);
    clr(); cycle("t4.idle");
    chk("t4.pending", pending, 2'd0);

    // 5: issue reg 7 while B for reg 7 drains
    query_reg2 = 5'd7;
    clr(); issue_valid = 1'b1; issue_reg = 5'd7; cycle("t5.issue");
    clr(); drive_a(5'd1, 32'h1); drive_b(5'd7, 32'h700); cycle("t5.push");
    clr(); issue_valid = 1'b1; issue_reg = 5'd7; cycle("t5.both");
    clr(); cycle("t5.hold");
    chk("t5.busy7", busy2, 1'b1);
    clr(); drive_b(5'd7, 32'h701); cycle("t5.push2");
    clr(); cycle("t5.drain");
    clr(); cycle("t5.clear");
    chk("t5.busy7_clr", busy2, 1'b0);

    // 6: reset mid-operation with 2 buffered entries and busy[3]
    query_reg1 = 5'd3;
    clr(); issue_valid = 1'b1; issue_reg = 5'd3; cycle("t6.issue");
    clr(); drive_a(5'd2, 32'h2); drive_b(5'd3, 32'h300); cycle("t6.p1");
    clr(); drive_a(5'd4, 32'h4); drive_b(5'd12, 32'hC00); cycle("t6.p2");
    chk("t6.full", pending, 2'd2);
    chk("t6.busy3", busy1, 1'b1);
    clr();
    a_valid = 1'b1; a_reg = 5'd6; a_data = 32'h6;
    reset = 1'b1;
    #1;
    chk("t6.rst_wr_en", wr_en, 1'b0);
    chk("t6.rst_b_ready", b_ready, 1'b0);
    chk("t6.rst_pending", pending, 2'd0);
    chk("t6.rst_busy", busy1, 1'b0);
    clr();
    qa.delete(); qb.delete(); busy_m = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clr(); cycle("t6.post");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
